// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input circuit through all 8 input patterns and holds each one for
// HOLD_CYCLES clocks. It captures {x,y} at the end of each hold and grades it against EXPECTED.
module truth_table_sweeper #(
    parameter int          HOLD_CYCLES = 2,
    parameter logic [15:0] EXPECTED    = 16'hD668
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        x_in,
    input  logic        y_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] result,
    output logic [3:0]  mismatch_count,
    output logic [2:0]  first_fail
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

    state_t      state, state_d;
    logic [2:0]  row, row_d;
    logic [7:0]  cnt, cnt_d;
    logic [15:0] result_d;
    logic [3:0]  mc_d;
    logic [2:0]  ff_d;
    logic        pass_d;
    logic [2:0]  abc_q, abc_d;
    logic [1:0]  sample, exp_row;

    assign sample  = {x_in, y_in};
    assign exp_row = EXPECTED[{row, 1'b0} +: 2];

    always_comb begin
        state_d  = state;
        row_d    = row;
        cnt_d    = cnt;
        result_d = result;
        mc_d     = mismatch_count;
        ff_d     = first_fail;
        pass_d   = pass;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = DRIVE;
                    row_d    = 3'd0;
                    cnt_d    = 8'd0;
                    result_d = 16'h0000;
                    mc_d     = 4'd0;
                    ff_d     = 3'd0;
                    pass_d   = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt != LAST) begin
                    cnt_d = cnt + 8'd1;
                end else begin
                    result_d[{row, 1'b0} +: 2] = sample;
                    if (sample != exp_row) begin
                        mc_d = mismatch_count + 4'd1;
                        // Only the lowest failing row is reported.
                        if (mismatch_count == 4'd0) ff_d = row;
                    end
                    cnt_d = 8'd0;
                    if (row == 3'd7) begin
                        state_d = DONE;
                        pass_d  = (mc_d == 4'd0);
                    end else begin
                        row_d = row + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Stimulus is registered from the next-state row so it tracks row exactly while in DRIVE.
        abc_d = (state_d == DRIVE) ? row_d : 3'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            row            <= 3'd0;
            cnt            <= 8'd0;
            result         <= 16'h0000;
            mismatch_count <= 4'd0;
            first_fail     <= 3'd0;
            pass           <= 1'b0;
            abc_q          <= 3'd0;
        end else begin
            state          <= state_d;
            row            <= row_d;
            cnt            <= cnt_d;
            result         <= result_d;
            mismatch_count <= mc_d;
            first_fail     <= ff_d;
            pass           <= pass_d;
            abc_q          <= abc_d;
        end
    end

    assign {a, b, c} = abc_q;
    assign busy      = (state == DRIVE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper. It uses a full-adder model with injectable faults and
// tests HOLD_CYCLES = 2 and HOLD_CYCLES = 1.
module tb_truth_table_sweeper;

    typedef struct {
        int          fault;
        logic [15:0] res;
        logic [3:0]  mc;
        logic [2:0]  ff;
        logic        ps;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start0, x0, y0, a0, b0, c0, busy0, done0, pass0;
    logic [15:0] result0;
    logic [3:0]  mc0;
    logic [2:0]  ff0;
    logic        start1, x1, y1, a1, b1, c1, busy1, done1, pass1;
    logic [15:0] result1;
    logic [3:0]  mc1;
    logic [2:0]  ff1;

    int   fault0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[3];
    vec_t exp_q[$];

    // Circuit under test: full adder, optionally all-zero (1) or row-6 carry inverted (2).
    function automatic logic [1:0] model(input logic [2:0] r, input int mode);
        logic s, cy;
        s  = ^r;
        cy = (r[2] & r[1]) | (r[2] & r[0]) | (r[1] & r[0]);
        if (mode == 1) begin
            s  = 1'b0;
            cy = 1'b0;
        end
        if (mode == 2 && r == 3'd6) cy = ~cy;
        return {s, cy};
    endfunction

    assign {x0, y0} = model({a0, b0, c0}, fault0);
    assign {x1, y1} = model({a1, b1, c1}, 0);

    truth_table_sweeper #(.HOLD_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start0), .x_in(x0), .y_in(y0),
        .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
        .result(result0), .mismatch_count(mc0), .first_fail(ff0)
    );

    truth_table_sweeper #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .x_in(x1), .y_in(y1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .result(result1), .mismatch_count(mc1), .first_fail(ff1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic score(input string tag, input logic [15:0] res, input logic [3:0] mc,
                         input logic [2:0] ff, input logic ps);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: output with empty scoreboard", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".result"}, res, e.res);
            chk({tag, ".mismatch_count"}, mc, e.mc);
            chk({tag, ".first_fail"}, ff, e.ff);
            chk({tag, ".pass"}, ps, e.ps);
        end
    endtask

    // Runs one HOLD_CYCLES=2 sweep. A restart pulse is issued at cycle restart_at, if one is given.
    task automatic sweep2(input int restart_at, input bit chk_abc);
        int n;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        n = 0;
        while (!done0 && n < 100) begin
            if (chk_abc) begin
                chk("abc2", {a0, b0, c0}, n / 2);
                chk("busy2", busy0, 1);
            end
            start0 = (n == restart_at);
            @(negedge clk);
            n++;
        end
        start0 = 1'b0;
        chk("sweep2_len", n, 16);
        chk("idle_abc2", {a0, b0, c0}, 0);
        chk("busy2_after", busy0, 0);
        score("hold2", result0, mc0, ff0, pass0);
    endtask

    task automatic sweep1_tail();
        int n;
        n = 0;
        while (!done1 && n < 100) begin
            chk("abc1", {a1, b1, c1}, n);
            @(negedge clk);
            n++;
        end
        chk("sweep1_len", n, 8);
        score("hold1", result1, mc1, ff1, pass1);
    endtask

    initial begin
        int n;
        tbl[0] = '{0, 16'hD668, 4'd0, 3'd0, 1'b1};
        tbl[1] = '{1, 16'h0000, 4'd7, 3'd1, 1'b0};
        tbl[2] = '{2, 16'hC668, 4'd1, 3'd6, 1'b0};

        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; fault0 = 0;
        #12;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_abc", {a0, b0, c0}, 0);
        chk("rst_result", result0, 0);
        chk("rst_mc", mc0, 0);
        chk("rst_ff", ff0, 0);
        @(negedge clk); reset = 1'b0;

        // Table-driven sweeps: correct adder, outputs tied low, row-6 carry fault.
        for (int i = 0; i < 3; i++) begin
            fault0 = tbl[i].fault;
            exp_q.push_back(tbl[i]);
            sweep2(-1, (i == 0));
        end

        // Restart attempt 5 clocks into a sweep must be ignored.
        fault0 = 0;
        exp_q.push_back(tbl[0]);
        sweep2(5, 1'b1);

        // Async reset in row 4, between clock edges.
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        n = 0;
        while (n < 9) begin
            @(negedge clk);
            n++;
        end
        chk("row4_abc", {a0, b0, c0}, 4);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy0, 0);
        chk("arst_done", done0, 0);
        chk("arst_pass", pass0, 0);
        chk("arst_abc", {a0, b0, c0}, 0);
        chk("arst_result", result0, 0);
        chk("arst_mc", mc0, 0);
        chk("arst_ff", ff0, 0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("arst_idle", busy0, 0);
        exp_q.push_back(tbl[0]);
        sweep2(-1, 1'b0);

        // HOLD_CYCLES=1: one sweep, then a restart from DONE.
        exp_q.push_back(tbl[0]);
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        sweep1_tail();
        chk("done1_held", done1, 1);
        exp_q.push_back(tbl[0]);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_done1", done1, 0);
        chk("restart_busy1", busy1, 1);
        start1 = 1'b0;
        @(negedge clk);
        sweep1_tail();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
